// File: rtl/glb_pkg.sv
// Shared types and helpers for the GLB buffer loader.
package glb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Fibonacci taps for x^16+x^14+x^13+x^11+1 (register bits 15,13,12,10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Column id runs 1..num_col, so one extra bit over the index width
   function automatic int id_width(input int num_col);
      return $clog2(num_col) + 1;
   endfunction

endpackage

// File: rtl/glb_lfsr.sv
// One lane of the pseudo-random beat source (built only with GLB_LFSR_SRC_EN).
// Presents the current state as lane data; steps once per accepted beat.
`ifdef GLB_LFSR_SRC_EN
module glb_lfsr
   import glb_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        load,
   input  logic        adv,
   output logic [15:0] value
);

   logic fb_p0;

   assign fb_p0 = ^(value & LFSR_TAPS);

   // Re-seed on a new load, otherwise shift in feedback on each beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         value <= SEED;
      end else if (load) begin
         value <= SEED;
      end else if (adv) begin
         value <= {value[14:0], fb_p0};
      end
   end

endmodule
`endif

// File: rtl/glb_buffer_loader.sv
// GLB buffer loader: streams multi-lane beats into the global buffer,
// tagging each write with a column id 1..kernel_size and a wrapping address.
// Build option GLB_LFSR_SRC_EN: beat data comes from per-lane LFSRs instead of s_data.
module glb_buffer_loader
   import glb_pkg::*;
#(
   parameter int          DATA_WIDTH  = 16,
   parameter int          NUM_LANES   = 4,
   parameter int          NUM_COL     = 8,
   parameter int          BUFFER_SIZE = 512,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   localparam int         ADDR_W      = $clog2(BUFFER_SIZE),
   localparam int         ID_W        = id_width(NUM_COL),
   localparam int         BEAT_W      = DATA_WIDTH * NUM_LANES
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [7:0]        cfg_kernel_size,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BEAT_W-1:0] s_data,
   input  logic              glb_full,
   output logic              wr_en,
   output logic [BEAT_W-1:0] wr_data,
   output logic [ID_W-1:0]   wr_id,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state;
   logic [ID_W-1:0]   ks_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   beat_cnt;
   logic [ID_W-1:0]   id_q;
   logic [ADDR_W-1:0] addr_q;

   logic              ks_ok;
   logic              last_p0;
   logic              acc_p0;
   logic [BEAT_W-1:0] beat_p0;

   assign ks_ok   = (cfg_kernel_size != 8'd0) && (cfg_kernel_size <= 8'(NUM_COL));
   assign last_p0 = ((beat_cnt + (ADDR_W+1)'(1)) == len_q);

`ifdef GLB_LFSR_SRC_EN
   logic unused_stream;
   assign unused_stream = ^{s_valid, s_data};

   // Source is always ready while loading; only GLB back-pressure stalls it
   assign s_ready = 1'b0;
   assign acc_p0  = (state == LOAD) && !glb_full;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [15:0] LANE_SEED = LFSR_SEED ^ 16'(i);
      logic [15:0] lane_val;

      glb_lfsr #(.SEED(LANE_SEED)) u_lfsr (
         .clk   (clk),
         .rstn  (rstn),
         .load  ((state == IDLE) && start),
         .adv   (acc_p0),
         .value (lane_val)
      );

      assign beat_p0[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lane_val);
   end
`else
   localparam logic [15:0] unused_seed = LFSR_SEED;

   // Ready drops combinationally with glb_full so no beat is taken that cannot be written
   assign s_ready = (state == LOAD) && !glb_full;
   assign acc_p0  = s_valid && s_ready;
   assign beat_p0 = s_data;
`endif

   // Control FSM plus the registered write port (one cycle after acceptance)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         ks_q     <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         id_q     <= '0;
         addr_q   <= '0;
         wr_en    <= 1'b0;
         wr_data  <= '0;
         wr_id    <= '0;
         wr_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (!ks_ok) begin
                     err <= 1'b1;
                  end else begin
                     ks_q     <= cfg_kernel_size[ID_W-1:0];
                     len_q    <= cfg_len;
                     addr_q   <= cfg_base_addr;
                     id_q     <= ID_W'(1);
                     beat_cnt <= '0;
                     if (cfg_len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= LOAD;
                        busy  <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               if (acc_p0) begin
                  wr_en    <= 1'b1;
                  wr_data  <= beat_p0;
                  wr_id    <= id_q;
                  wr_addr  <= addr_q;
                  beat_cnt <= beat_cnt + (ADDR_W+1)'(1);
                  id_q     <= (id_q == ks_q) ? ID_W'(1) : id_q + ID_W'(1);
                  addr_q   <= (addr_q == ADDR_W'(BUFFER_SIZE-1)) ? '0 : addr_q + ADDR_W'(1);
                  if (last_p0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_glb_buffer_loader.sv
// Scoreboard bench for glb_buffer_loader: expected writes are queued when a
// load is set up and popped as wr_en appears.
module tb_glb_buffer_loader;

   localparam int DW = 16;
   localparam int NL = 4;
   localparam int BW = DW * NL;

   typedef struct {
      logic [BW-1:0] data;
      logic [3:0]    id;
      logic [8:0]    addr;
   } exp_t;

   logic          clk;
   logic          rstn;
   logic          start;
   logic [7:0]    cfg_kernel_size;
   logic [8:0]    cfg_base_addr;
   logic [9:0]    cfg_len;
   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] s_data;
   logic          glb_full;
   logic          wr_en;
   logic [BW-1:0] wr_data;
   logic [3:0]    wr_id;
   logic [8:0]    wr_addr;
   logic          busy;
   logic          done;
   logic          err;

   int total = 0;
   int bad   = 0;

   exp_t          exp_q[$];
   logic [BW-1:0] src_q[$];
   logic [15:0]   lfsr_m[NL];

   glb_buffer_loader dut (
      .clk             (clk),
      .rstn            (rstn),
      .start           (start),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_base_addr   (cfg_base_addr),
      .cfg_len         (cfg_len),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .glb_full        (glb_full),
      .wr_en           (wr_en),
      .wr_data         (wr_data),
      .wr_id           (wr_id),
      .wr_addr         (wr_addr),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next beat of source data: random words, or the golden LFSR lanes
   function automatic logic [BW-1:0] next_beat();
      logic [BW-1:0] d;
`ifdef GLB_LFSR_SRC_EN
      for (int i = 0; i < NL; i++) begin
         d[i*DW +: DW] = lfsr_m[i];
         lfsr_m[i] = {lfsr_m[i][14:0], lfsr_m[i][15] ^ lfsr_m[i][13] ^ lfsr_m[i][12] ^ lfsr_m[i][10]};
      end
`else
      d = {$urandom(), $urandom()};
`endif
      return d;
   endfunction

   // Drive one load and score every write; optional back-pressure window, mid-load restart, reset abort
   task automatic run_load(input int ks, input int base, input int len, input int full_lo,
                           input int full_hi, input int restart_at, input int abort_after);
      int   idx;
      int   nwr;
      int   ndone;
      bit   fin;
      bit   aborted;
      bit   acc;
      logic exp_done;
      exp_t e;
      exp_q.delete();
      src_q.delete();
      for (int i = 0; i < NL; i++) lfsr_m[i] = 16'hACE1 ^ 16'(i);
      for (int k = 0; k < len; k++) begin
         e.data = next_beat();
         e.id   = 4'(1 + (k % ks));
         e.addr = 9'((base + k) % 512);
         src_q.push_back(e.data);
         exp_q.push_back(e);
      end
      @(negedge clk);
      cfg_kernel_size = 8'(ks);
      cfg_base_addr   = 9'(base);
      cfg_len         = 10'(len);
      start           = 1'b1;
      glb_full        = 1'b0;
      s_valid         = 1'b1;
      s_data          = src_q[0];
      idx = 0; nwr = 0; ndone = 0; fin = 1'b0; aborted = 1'b0;
      for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_load: got %b want 1", busy); end
         end
         total++;
         if (err !== 1'b0) begin bad++; $display("FAIL err_in_load: got %b want 0 (cyc %0d)", err, cyc); end
         if (wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL extra_write: addr %0d id %0d beyond %0d beats", wr_addr, wr_id, len);
            end else begin
               e = exp_q.pop_front();
               nwr++;
               if ({wr_data, wr_id, wr_addr} !== {e.data, e.id, e.addr}) begin
                  bad++;
                  $display("FAIL write_%0d: got data %h id %0d addr %0d want data %h id %0d addr %0d",
                           nwr, wr_data, wr_id, wr_addr, e.data, e.id, e.addr);
               end
            end
         end
         exp_done = (wr_en === 1'b1) && (nwr == len);
         total++;
         if (done !== exp_done) begin bad++; $display("FAIL done_timing: got %b want %b (write %0d)", done, exp_done, nwr); end
         if (done === 1'b1) begin ndone++; fin = 1'b1; end
         if (abort_after >= 0 && nwr == abort_after) begin
            rstn = 1'b0;
            #1;
            total++;
            if ({wr_en, wr_data, wr_id, wr_addr, busy, done, err, s_ready} !== '0) begin
               bad++;
               $display("FAIL abort_outputs: got en %b data %h id %0d addr %0d busy %b done %b err %b rdy %b want all 0",
                        wr_en, wr_data, wr_id, wr_addr, busy, done, err, s_ready);
            end
            aborted = 1'b1;
            fin = 1'b1;
         end
         if (!fin) begin
            start = (cyc == restart_at);
            if (start) begin
               cfg_kernel_size = 8'd2;
               cfg_base_addr   = 9'd100;
               cfg_len         = 10'd3;
            end
            glb_full = (cyc >= full_lo) && (cyc <= full_hi);
            s_data   = (idx < src_q.size()) ? src_q[idx] : '0;
            #1;
            if (glb_full) begin
               total++;
               if (s_ready !== 1'b0) begin bad++; $display("FAIL ready_when_full: got %b want 0", s_ready); end
            end
`ifndef GLB_LFSR_SRC_EN
            else if (idx < len) begin
               total++;
               if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_in_load: got %b want 1 (beat %0d)", s_ready, idx); end
            end
            acc = s_valid && (s_ready === 1'b1);
`else
            acc = !glb_full && (idx < len);
`endif
            if (acc) idx++;
         end
      end
      start    = 1'b0;
      glb_full = 1'b0;
      if (!aborted) begin
         total++;
         if (nwr != len || exp_q.size() != 0 || ndone != 1) begin
            bad++; $display("FAIL load_count: got %0d writes %0d done want %0d writes 1 done", nwr, ndone, len);
         end
         @(negedge clk);
         total++;
         if ({done, busy, wr_en} !== 3'b000) begin
            bad++; $display("FAIL after_done: got done %b busy %b wr_en %b want 0 0 0", done, busy, wr_en);
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({wr_en, wr_data, wr_id, wr_addr, busy, done, err, s_ready} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got en %b data %h id %0d addr %0d busy %b done %b err %b rdy %b want all 0",
                  wr_en, wr_data, wr_id, wr_addr, busy, done, err, s_ready);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_id_wrap();
      run_load(3, 0, 7, -1, -1, -1, -1);
   endtask

   task automatic test_addr_wrap();
      run_load(4, 510, 4, -1, -1, -1, -1);
   endtask

   task automatic test_backpressure();
      run_load(8, 40, 8, 3, 5, -1, -1);
   endtask

   task automatic test_bad_ks(input int ks);
      @(negedge clk);
      cfg_kernel_size = 8'(ks);
      cfg_base_addr   = 9'd0;
      cfg_len         = 10'd5;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({err, busy, wr_en} !== 3'b100) begin
         bad++; $display("FAIL bad_ks_%0d: got err %b busy %b wr_en %b want 1 0 0", ks, err, busy, wr_en);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({err, busy, wr_en, done} !== 4'b0000) begin
            bad++; $display("FAIL bad_ks_%0d_after: got err %b busy %b wr_en %b done %b want 0", ks, err, busy, wr_en, done);
         end
      end
   endtask

   task automatic test_len0_and_restart();
      int ndone;
      int nwr;
      ndone = 0; nwr = 0;
      @(negedge clk);
      cfg_kernel_size = 8'd3;
      cfg_base_addr   = 9'd7;
      cfg_len         = 10'd0;
      start           = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) ndone++;
         if (wr_en === 1'b1) nwr++;
         total++;
         if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b want 0", busy); end
         @(negedge clk);
      end
      total++;
      if (ndone != 1 || nwr != 0) begin
         bad++; $display("FAIL len0: got %0d done %0d writes want 1 done 0 writes", ndone, nwr);
      end
      run_load(3, 0, 6, -1, -1, 2, -1);
   endtask

   task automatic test_reset_mid();
      run_load(3, 20, 10, -1, -1, -1, 4);
      @(negedge clk);
      rstn = 1'b1;
      run_load(3, 0, 5, -1, -1, -1, -1);
   endtask

   task automatic test_back_to_back();
      run_load(1, 300, 3, -1, -1, -1, -1);
      run_load(8, 505, 9, 0, 1, -1, -1);
   endtask

   initial begin
      rstn            = 1'b0;
      start           = 1'b0;
      cfg_kernel_size = '0;
      cfg_base_addr   = '0;
      cfg_len         = '0;
      s_valid         = 1'b0;
      s_data          = '0;
      glb_full        = 1'b0;
      test_reset();
      test_id_wrap();
      test_addr_wrap();
      test_backpressure();
      test_bad_ks(0);
      test_bad_ks(9);
      test_len0_and_restart();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
